down_counter_timer: RTL and testbench

- Loadable synchronous down-counter with underflow detection; the count-down counterpart to the team's 4-bit up-counter with overflow.
- Software or an upstream FSM loads a start value; the block decrements on each enabled cycle and flags underflow.
- Runs in one-shot mode (stops at expiry) or auto-reload mode (periodic tick).
- Used as a timeout/interval timer alongside the existing counters.

---
 rtl/down_counter_timer_if.sv | 27 ++
 rtl/down_counter_timer.sv | 103 ++++++++++
 tb/tb_down_counter_timer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// master: drives enable/load/load_value/auto_reload/clear_underflow and
//         observes counter_out/underflow_out/underflow_pulse/busy.
// slave : the timer side of the same signals.
interface down_counter_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic             clear_underflow;
    logic [WIDTH-1:0] counter_out;
    logic             underflow_out;
    logic             underflow_pulse;
    logic             busy;

    modport master (
        output enable, load, load_value, auto_reload, clear_underflow,
        input  counter_out, underflow_out, underflow_pulse, busy
    );

    modport slave (
        input  enable, load, load_value, auto_reload, clear_underflow,
        output counter_out, underflow_out, underflow_pulse, busy
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with underflow detection, one-shot or
// auto-reload operation.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - synchronous, active-high reset
//   bus   - slave side of down_counter_timer_if:
//           enable, load, load_value, auto_reload, clear_underflow (in)
//           counter_out, underflow_out, underflow_pulse, busy (out)
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    down_counter_timer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             underflow_q, underflow_d;
    logic             pulse_q, pulse_d;
    logic             underflow_event_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
            pulse_q     <= pulse_d;
        end
    end

    // Underflow happens on an enabled cycle at zero, unless a load pre-empts it
    assign underflow_event_c = (state_q == RUN) && bus.enable &&
                               (count_q == '0) && !bus.load;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = underflow_q;
        pulse_d     = 1'b0;

        // Clear first so a simultaneous underflow event overrides it
        if (bus.clear_underflow) begin
            underflow_d = 1'b0;
        end

        if (bus.load) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            state_d  = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (underflow_event_c) begin
                        pulse_d     = 1'b1;
                        underflow_d = 1'b1;
                        if (bus.auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = EXPIRED;
                        end
                    end else if (bus.enable) begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign bus.counter_out     = count_q;
    assign bus.underflow_out   = underflow_q;
    assign bus.underflow_pulse = pulse_q;
    assign bus.busy            = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 4;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling / driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [WIDTH-1:0] cnt,
                              input logic uf, input logic pl, input logic bz);
        check({tag, ".counter_out"},     32'(bus.counter_out),     32'(cnt));
        check({tag, ".underflow_out"},   32'(bus.underflow_out),   32'(uf));
        check({tag, ".underflow_pulse"}, 32'(bus.underflow_pulse), 32'(pl));
        check({tag, ".busy"},            32'(bus.busy),            32'(bz));
    endtask

    // Auto-reload expectations after each enabled cycle following load 2
    logic [WIDTH-1:0] ar_cnt   [8] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
    logic             ar_pulse [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic             ar_uf    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset held two cycles with load and enable active
        reset               = 1'b1;
        bus.enable          = 1'b1;
        bus.load            = 1'b1;
        bus.load_value      = 4'd9;
        bus.auto_reload     = 1'b0;
        bus.clear_underflow = 1'b0;
        tick();
        tick();
        expect_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // IDLE ignores enable
        reset    = 1'b0;
        bus.load = 1'b0;
        tick();
        expect_out("idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // One-shot: load 3
        bus.load = 1'b1; bus.load_value = 4'd3; bus.auto_reload = 1'b0;
        tick();
        expect_out("os_load", 4'd3, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0;
        tick(); expect_out("os_c1", 4'd2, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("os_c2", 4'd1, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("os_c3", 4'd0, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("os_evt", 4'd0, 1'b1, 1'b1, 1'b0);
        tick(); expect_out("os_exp1", 4'd0, 1'b1, 1'b0, 1'b0);
        tick(); expect_out("os_exp2", 4'd0, 1'b1, 1'b0, 1'b0);
        bus.clear_underflow = 1'b1;
        tick(); expect_out("os_clr", 4'd0, 1'b0, 1'b0, 1'b0);
        bus.clear_underflow = 1'b0;

        // Auto-reload: load 2, nine observed values 2,1,0,2,1,0,2,1,0
        bus.load = 1'b1; bus.load_value = 4'd2; bus.auto_reload = 1'b1;
        tick();
        expect_out("ar_load", 4'd2, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out($sformatf("ar_c%0d", i + 1), ar_cnt[i], ar_uf[i], ar_pulse[i], 1'b1);
        end

        // Clear sticky flag while holding (enable low)
        bus.enable = 1'b0; bus.clear_underflow = 1'b1;
        tick(); expect_out("hold_clr", 4'd0, 1'b0, 1'b0, 1'b1);
        bus.clear_underflow = 1'b0;

        // Load 7 on an underflow-event cycle: load wins, no pulse, no sticky set
        bus.enable = 1'b1; bus.load = 1'b1; bus.load_value = 4'd7;
        tick(); expect_out("prio_load", 4'd7, 1'b0, 1'b0, 1'b1);

        // Load 0 one-shot, then clear_underflow on the event cycle: event wins
        bus.load_value = 4'd0; bus.auto_reload = 1'b0;
        tick(); expect_out("prio_ld0", 4'd0, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0; bus.clear_underflow = 1'b1;
        tick(); expect_out("prio_clr", 4'd0, 1'b1, 1'b1, 1'b0);
        bus.clear_underflow = 1'b0;

        // Reload value 0 with auto-reload: pulse every enabled cycle
        bus.load = 1'b1; bus.load_value = 4'd0; bus.auto_reload = 1'b1;
        bus.clear_underflow = 1'b1;
        tick(); expect_out("b2b_load", 4'd0, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0; bus.clear_underflow = 1'b0;
        tick(); expect_out("b2b_e1", 4'd0, 1'b1, 1'b1, 1'b1);
        tick(); expect_out("b2b_e2", 4'd0, 1'b1, 1'b1, 1'b1);
        tick(); expect_out("b2b_e3", 4'd0, 1'b1, 1'b1, 1'b1);

        // Enable gating: load 5, enable 1,0,0,1 -> 4,4,4,3
        bus.load = 1'b1; bus.load_value = 4'd5; bus.auto_reload = 1'b0;
        bus.clear_underflow = 1'b1;
        tick(); expect_out("gate_load", 4'd5, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0; bus.clear_underflow = 1'b0;
        bus.enable = 1'b1; tick(); expect_out("gate_1", 4'd4, 1'b0, 1'b0, 1'b1);
        bus.enable = 1'b0; tick(); expect_out("gate_2", 4'd4, 1'b0, 1'b0, 1'b1);
        bus.enable = 1'b0; tick(); expect_out("gate_3", 4'd4, 1'b0, 1'b0, 1'b1);
        bus.enable = 1'b1; tick(); expect_out("gate_4", 4'd3, 1'b0, 1'b0, 1'b1);

        // Reset mid-count: load 15, five enabled cycles to 10, then reset
        bus.load = 1'b1; bus.load_value = 4'd15;
        tick(); expect_out("rmc_load", 4'd15, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        expect_out("rmc_cnt", 4'd10, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick(); expect_out("rmc_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); expect_out("rmc_idle1", 4'd0, 1'b0, 1'b0, 1'b0);
        tick(); expect_out("rmc_idle2", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
